// File: rtl/gray_code_counter.sv
// gray_code_counter
//   Registered up/down counter with a Gray-coded output bus for the
//   gray_to_binary stage downstream. The binary count is carried alongside
//   for self-checking. Each count step flips exactly one gray_out bit, so the
//   bus can be sampled with skew or across a clock domain boundary. Clear and
//   load are explicit jumps that can flip several bits; they are flagged on
//   the jump output.
//
// Parameters
//   WIDTH    count width in bits (>= 2)
//   RST_VAL  binary value taken on reset and on clr
//   WRAP_EN  1: wrap modulo 2^WIDTH; 0: saturate at 0 and at 2^WIDTH-1
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   clr       in   1      synchronous clear to RST_VAL (highest priority)
//   load      in   1      synchronous load of load_val (beats en)
//   load_val  in   WIDTH  binary value to load
//   en        in   1      count enable
//   up_dn     in   1      1 = increment, 0 = decrement
//   gray_out  out  WIDTH  registered Gray count
//   bin_out   out  WIDTH  registered binary count, aligned with gray_out
//   wrap      out  1      1-cycle pulse: count wrapped, or hit its limit when saturating
//   jump      out  1      1-cycle pulse: count changed by clr or load

module gray_code_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned RST_VAL = 0,
    parameter bit          WRAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap,
    output logic             jump
);

    localparam logic [WIDTH-1:0] RST_BIN  = RST_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [WIDTH-1:0] MAX_CNT  = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic             jump_q;

    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;
    logic             jump_nxt;

    // Next-state: clr > load > en. load_val is only looked at under load,
    // so an undriven load_val cannot leak into the count.
    always_comb begin
        bin_nxt  = bin_q;
        wrap_nxt = 1'b0;
        jump_nxt = 1'b0;
        if (clr) begin
            bin_nxt  = RST_BIN;
            jump_nxt = (bin_q != RST_BIN);
        end else if (load) begin
            bin_nxt  = load_val;
            jump_nxt = (bin_q != load_val);
        end else if (en) begin
            if (up_dn) begin
                if (bin_q == MAX_CNT) begin
                    wrap_nxt = 1'b1;
                    bin_nxt  = WRAP_EN ? '0 : bin_q;
                end else begin
                    bin_nxt = bin_q + ONE;
                end
            end else begin
                if (bin_q == '0) begin
                    wrap_nxt = 1'b1;
                    bin_nxt  = WRAP_EN ? MAX_CNT : bin_q;
                end else begin
                    bin_nxt = bin_q - ONE;
                end
            end
        end
        // Gray is encoded before the flops so the registered bus never
        // carries decode glitches and stays aligned with bin_q.
        gray_nxt = bin_nxt ^ (bin_nxt >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
            jump_q <= 1'b0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= gray_nxt;
            wrap_q <= wrap_nxt;
            jump_q <= jump_nxt;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;
    assign jump     = jump_q;

endmodule

// File: tb/tb_gray_code_counter.sv
module tb_gray_code_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         en = 1'b0;
    logic         up_dn = 1'b0;

    logic [W-1:0] gray_a, bin_a, gray_b, bin_b;
    logic         wrap_a, jump_a, wrap_b, jump_b;

    int compared   = 0;
    int mismatched = 0;

    // clock/reset block
    always #5 clk = ~clk;

    gray_code_counter #(.WIDTH(W), .RST_VAL(0), .WRAP_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn),
        .gray_out(gray_a), .bin_out(bin_a), .wrap(wrap_a), .jump(jump_a)
    );

    gray_code_counter #(.WIDTH(W), .RST_VAL(0), .WRAP_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn),
        .gray_out(gray_b), .bin_out(bin_b), .wrap(wrap_b), .jump(jump_b)
    );

    typedef struct {
        logic         clr;
        logic         load;
        logic [W-1:0] load_val;
        logic         en;
        logic         up_dn;
        logic [W-1:0] exp_bin;
        logic [W-1:0] exp_gray;
        logic         exp_wrap;
        logic         exp_jump;
    } vec_t;

    vec_t vecs[$];

    // hand-computed Gray sequence for 0..15
    logic [W-1:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    function automatic vec_t mk(input logic c, input logic l, input logic [W-1:0] lv,
                                input logic e, input logic u, input logic [W-1:0] b,
                                input logic [W-1:0] g, input logic w, input logic j);
        vec_t v;
        v.clr = c; v.load = l; v.load_val = lv; v.en = e; v.up_dn = u;
        v.exp_bin = b; v.exp_gray = g; v.exp_wrap = w; v.exp_jump = j;
        return v;
    endfunction

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // scoreboard compare
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: present inputs, take one edge, settle past it
    task automatic apply(input logic c, input logic l, input logic [W-1:0] lv,
                         input logic e, input logic u);
        clr = c; load = l; load_val = lv; en = e; up_dn = u;
        @(posedge clk);
        #1;
    endtask

    // reference model: integer arithmetic, range checked after the step
    task automatic model_step(input int cur, input bit wrap_en, input bit c, input bit l,
                              input int lv, input bit e, input bit u,
                              output int nxt, output bit w, output bit j);
        int t;
        nxt = cur; w = 0; j = 0;
        if (c) begin
            nxt = 0; j = (cur != 0);
        end else if (l) begin
            nxt = lv; j = (cur != lv);
        end else if (e) begin
            t = u ? cur + 1 : cur - 1;
            if (t > 15 || t < 0) begin
                w = 1;
                nxt = wrap_en ? (t + 16) % 16 : cur;
            end else begin
                nxt = t;
            end
        end
    endtask

    initial begin
        int mdl_a, mdl_b, nxt_a, nxt_b;
        bit w_a, j_a, w_b, j_b;
        bit r_clr, r_load, r_en, r_up;
        int r_lv;
        logic [W-1:0] prev_ga, prev_gb;

        // table: 20 up steps from 0, then control corner cases
        for (int i = 0; i < 20; i++)
            vecs.push_back(mk(0, 0, 4'h0, 1, 1, 4'((i + 1) % 16), gseq[(i + 1) % 16],
                              (i + 1) == 16, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 1)); // clr from 4
        vecs.push_back(mk(0, 0, 4'h0, 1, 0, 4'hF, 4'h8, 1, 0)); // down from 0
        vecs.push_back(mk(0, 0, 4'h0, 1, 1, 4'h0, 4'h0, 1, 0)); // up from 15
        vecs.push_back(mk(0, 1, 4'hA, 1, 1, 4'hA, 4'hF, 0, 1)); // load beats en
        vecs.push_back(mk(1, 1, 4'h3, 1, 1, 4'h0, 4'h0, 0, 1)); // clr beats load
        vecs.push_back(mk(1, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0)); // clr, no change
        vecs.push_back(mk(0, 1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0)); // load, no change
        vecs.push_back(mk(0, 1, 4'h5, 0, 0, 4'h5, 4'h7, 0, 1)); // load 5
        vecs.push_back(mk(0, 0, 4'h0, 1, 1, 4'h6, 4'h5, 0, 0)); // reversal every cycle
        vecs.push_back(mk(0, 0, 4'h0, 1, 0, 4'h5, 4'h7, 0, 0));
        vecs.push_back(mk(0, 0, 4'h0, 1, 1, 4'h6, 4'h5, 0, 0));
        vecs.push_back(mk(0, 0, 4'h0, 1, 0, 4'h5, 4'h7, 0, 0));
        vecs.push_back(mk(0, 0, 4'h0, 0, 1, 4'h5, 4'h7, 0, 0)); // hold
        vecs.push_back(mk(0, 0, 4'h9, 0, 0, 4'h5, 4'h7, 0, 0)); // load_val ignored

        // reset state
        #2 rst = 1'b1;
        #1;
        check("rst_bin_a", 32'(bin_a), 32'h0);
        check("rst_gray_a", 32'(gray_a), 32'h0);
        check("rst_wrap_a", 32'(wrap_a), 32'h0);
        check("rst_jump_a", 32'(jump_a), 32'h0);
        check("rst_bin_b", 32'(bin_b), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].up_dn);
            check($sformatf("vec%0d_bin", i), 32'(bin_a), 32'(vecs[i].exp_bin));
            check($sformatf("vec%0d_gray", i), 32'(gray_a), 32'(vecs[i].exp_gray));
            check($sformatf("vec%0d_wrap", i), 32'(wrap_a), 32'(vecs[i].exp_wrap));
            check($sformatf("vec%0d_jump", i), 32'(jump_a), 32'(vecs[i].exp_jump));
        end

        // saturating down from 0 versus wrapping down
        apply(1, 0, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 4'h0, 1, 0);
            check("sat_dn_bin_b", 32'(bin_b), 32'h0);
            check("sat_dn_gray_b", 32'(gray_b), 32'h0);
            check("sat_dn_wrap_b", 32'(wrap_b), 32'h1);
            check("wrap_dn_bin_a", 32'(bin_a), 32'(15 - i));
        end

        // saturating up at 15 versus wrapping up
        apply(0, 1, 4'hF, 0, 0);
        apply(0, 0, 4'h0, 1, 1);
        check("wrap_up_bin_a", 32'(bin_a), 32'h0);
        check("wrap_up_wrap_a", 32'(wrap_a), 32'h1);
        check("sat_up_bin_b", 32'(bin_b), 32'hF);
        check("sat_up_gray_b", 32'(gray_b), 32'h8);
        check("sat_up_wrap_b", 32'(wrap_b), 32'h1);
        apply(0, 0, 4'h0, 1, 1);
        check("sat_up2_bin_b", 32'(bin_b), 32'hF);
        check("sat_up2_wrap_b", 32'(wrap_b), 32'h1);
        apply(0, 0, 4'h0, 0, 1);
        check("idle_wrap_b", 32'(wrap_b), 32'h0);

        // asynchronous reset mid-count
        apply(0, 1, 4'h9, 0, 0);
        check("pre_rst_bin_a", 32'(bin_a), 32'h9);
        check("pre_rst_jump_a", 32'(jump_a), 32'h1);
        en = 1'b1; up_dn = 1'b1; load = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_bin_a", 32'(bin_a), 32'h0);
        check("async_rst_gray_a", 32'(gray_a), 32'h0);
        check("async_rst_jump_a", 32'(jump_a), 32'h0);
        check("async_rst_wrap_a", 32'(wrap_a), 32'h0);
        @(posedge clk);
        #1;
        check("rst_held_bin_a", 32'(bin_a), 32'h0);
        rst = 1'b0;
        apply(0, 0, 4'h0, 1, 1);
        check("post_rst_bin_a", 32'(bin_a), 32'h1);
        check("post_rst_gray_a", 32'(gray_a), 32'h1);
        check("post_rst_bin_b", 32'(bin_b), 32'h1);

        // random run against the model, with Gray decode check
        mdl_a = 1; mdl_b = 1;
        prev_ga = 4'h1; prev_gb = 4'h1;
        for (int i = 0; i < 1000; i++) begin
            r_clr  = ($urandom_range(0, 15) == 0);
            r_load = ($urandom_range(0, 7) == 0);
            r_en   = ($urandom_range(0, 3) != 0);
            r_up   = $urandom_range(0, 1);
            r_lv   = $urandom_range(0, 15);
            model_step(mdl_a, 1, r_clr, r_load, r_lv, r_en, r_up, nxt_a, w_a, j_a);
            model_step(mdl_b, 0, r_clr, r_load, r_lv, r_en, r_up, nxt_b, w_b, j_b);
            apply(r_clr, r_load, 4'(r_lv), r_en, r_up);
            check("rnd_bin_a", 32'(bin_a), 32'(nxt_a));
            check("rnd_dec_a", 32'(g2b(gray_a)), 32'(nxt_a));
            check("rnd_wrap_a", 32'(wrap_a), 32'(w_a));
            check("rnd_jump_a", 32'(jump_a), 32'(j_a));
            check("rnd_bin_b", 32'(bin_b), 32'(nxt_b));
            check("rnd_dec_b", 32'(g2b(gray_b)), 32'(nxt_b));
            check("rnd_wrap_b", 32'(wrap_b), 32'(w_b));
            check("rnd_jump_b", 32'(jump_b), 32'(j_b));
            if (!r_clr && !r_load && r_en) begin
                check("rnd_step_bits_a", 32'($countones(prev_ga ^ gray_a)), 32'h1);
                check("rnd_step_bits_b", 32'($countones(prev_gb ^ gray_b)),
                      (nxt_b == mdl_b) ? 32'h0 : 32'h1);
            end
            mdl_a = nxt_a; mdl_b = nxt_b;
            prev_ga = 4'(nxt_a) ^ (4'(nxt_a) >> 1);
            prev_gb = 4'(nxt_b) ^ (4'(nxt_b) >> 1);
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
